// File: rtl/uart_tx_datapath_if.sv
// UART TX datapath bundle: FSM/upstream side drives through master,
// the bit-level datapath sits on slave.
interface uart_tx_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             serializer_load;
    logic [2:0]       sel_line;
    logic [3:0]       counter;
    logic             SRL_done;
    logic             TX_OUT;
    logic             tx_busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        output serializer_load,
        output sel_line,
        input  counter,
        input  SRL_done,
        input  TX_OUT,
        input  tx_busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        input  serializer_load,
        input  sel_line,
        output counter,
        output SRL_done,
        output TX_OUT,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_datapath.sv
// UART TX bit datapath: byte capture, parity, LSB-first shifter and a
// registered line mux steered by the TX control FSM.
module uart_tx_datapath #(
    parameter int WIDTH     = 8,
    parameter int SEL_IDLE  = 0,
    parameter int SEL_START = 1,
    parameter int SEL_STP   = 2,
    parameter int SEL_SRL   = 3,
    parameter int SEL_PAR   = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_datapath_if.slave   bus
);
    localparam logic [3:0] CNT_MAX = 4'(WIDTH);
    localparam logic [2:0] S_IDLE  = 3'(SEL_IDLE);
    localparam logic [2:0] S_START = 3'(SEL_START);
    localparam logic [2:0] S_STP   = 3'(SEL_STP);
    localparam logic [2:0] S_SRL   = 3'(SEL_SRL);
    localparam logic [2:0] S_PAR   = 3'(SEL_PAR);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_bit_q, par_bit_d;
    logic [3:0]       counter_q, counter_d;
    logic             srl_done_q, srl_done_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_busy_q, tx_busy_d;

    logic sel_idle, sel_start, sel_stp, sel_srl, sel_par;
    logic load;

    // Parity enable only matters to the FSM's sequencing.
    logic unused_par_en;
    assign unused_par_en = bus.PAR_EN;

    assign sel_idle  = (bus.sel_line == S_IDLE);
    assign sel_start = (bus.sel_line == S_START);
    assign sel_stp   = (bus.sel_line == S_STP);
    assign sel_srl   = (bus.sel_line == S_SRL);
    assign sel_par   = (bus.sel_line == S_PAR);

    assign load = bus.serializer_load && bus.DATA_VALID;

    always_comb begin
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        counter_d  = counter_q;
        srl_done_d = srl_done_q;
        // A load strobe owns the frame state even without valid data.
        if (bus.serializer_load) begin
            if (load) begin
                shreg_d    = bus.P_DATA;
                par_bit_d  = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
                counter_d  = 4'd0;
                srl_done_d = 1'b0;
            end
        end else if (sel_start) begin
            counter_d = 4'd1;
        end else if (sel_srl) begin
            if (counter_q < CNT_MAX) begin
                shreg_d   = shreg_q >> 1;
                counter_d = counter_q + 4'd1;
            end else begin
                srl_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_out_d  = 1'b1;
        tx_busy_d = 1'b0;
        unique case (1'b1)
            sel_start: begin
                tx_out_d  = 1'b0;
                tx_busy_d = 1'b1;
            end
            sel_srl: begin
                tx_out_d  = shreg_q[0];
                tx_busy_d = 1'b1;
            end
            sel_par: begin
                tx_out_d  = par_bit_q;
                tx_busy_d = 1'b1;
            end
            sel_idle, sel_stp: begin
                tx_out_d  = 1'b1;
                tx_busy_d = 1'b0;
            end
            default: begin
                tx_out_d  = 1'b1;
                tx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            counter_q  <= 4'd0;
            srl_done_q <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            counter_q  <= counter_d;
            srl_done_q <= srl_done_d;
            tx_out_q   <= tx_out_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign bus.counter  = counter_q;
    assign bus.SRL_done = srl_done_q;
    assign bus.TX_OUT   = tx_out_q;
    assign bus.tx_busy  = tx_busy_q;
endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath: frames, parity, mid-frame
// config changes, stray load strobes, illegal selects and reset.
module tb_uart_tx_datapath;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] STP   = 3'd2;
    localparam logic [2:0] SRL   = 3'd3;
    localparam logic [2:0] PAR   = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_datapath_if #(.WIDTH(8)) bus ();

    uart_tx_datapath #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic dv,
                         input logic [2:0] sel);
        bus.serializer_load = ld;
        bus.DATA_VALID      = dv;
        bus.sel_line        = sel;
    endtask

    task automatic check_state(input string tag, input logic tx,
                               input logic busy, input logic [3:0] cnt,
                               input logic done);
        check({tag, ".tx"}, 32'(bus.TX_OUT), 32'(tx));
        check({tag, ".busy"}, 32'(bus.tx_busy), 32'(busy));
        check({tag, ".cnt"}, 32'(bus.counter), 32'(cnt));
        check({tag, ".done"}, 32'(bus.SRL_done), 32'(done));
    endtask

    // Full frame; chg scrambles P_DATA/PAR_TYP after the first data bit.
    task automatic run_frame(input string nm, input logic [7:0] d,
                             input logic ptyp, input logic exp_par,
                             input logic chg);
        bus.P_DATA  = d;
        bus.PAR_TYP = ptyp;
        drive(1'b1, 1'b1, IDLE);
        tick();
        check_state({nm, ".load"}, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, START);
        tick();
        check_state({nm, ".start"}, 1'b0, 1'b1, 4'd1, 1'b0);
        drive(1'b0, 1'b0, SRL);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_state($sformatf("%s.d%0d", nm, k), d[k], 1'b1,
                        (k < 7) ? 4'(k + 2) : 4'd8, k == 7);
            if (chg && k == 0) begin
                bus.P_DATA  = 8'h00;
                bus.PAR_TYP = ~ptyp;
            end
        end
        drive(1'b0, 1'b0, PAR);
        tick();
        check_state({nm, ".par"}, exp_par, 1'b1, 4'd8, 1'b1);
        drive(1'b0, 1'b0, STP);
        tick();
        check_state({nm, ".stp"}, 1'b1, 1'b0, 4'd8, 1'b1);
        drive(1'b0, 1'b0, IDLE);
        tick();
        check_state({nm, ".idle"}, 1'b1, 1'b0, 4'd8, 1'b1);
    endtask

    initial begin
        bus.P_DATA = 8'h00;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        drive(1'b0, 1'b0, IDLE);
        repeat (2) tick();
        check_state("rst", 1'b1, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        tick();
        check_state("rst_rel", 1'b1, 1'b0, 4'd0, 1'b0);

        // 0xA5 even: parity 0; 0x07 odd: 0; 0x03 odd: 1; 0xFF even: 0
        run_frame("even_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        run_frame("odd_07", 8'h07, 1'b1, 1'b0, 1'b0);
        run_frame("odd_03", 8'h03, 1'b1, 1'b1, 1'b0);
        run_frame("cfg_ff", 8'hFF, 1'b0, 1'b0, 1'b1);

        // Partial frame of 0x0F, then stray strobe and illegal select.
        bus.P_DATA  = 8'h0F;
        bus.PAR_TYP = 1'b0;
        drive(1'b1, 1'b1, IDLE);
        tick();
        drive(1'b0, 1'b0, START);
        tick();
        drive(1'b0, 1'b0, SRL);
        tick();
        check_state("p.d0", 1'b1, 1'b1, 4'd2, 1'b0);
        tick();
        check_state("p.d1", 1'b1, 1'b1, 4'd3, 1'b0);
        bus.P_DATA = 8'h3C;
        drive(1'b1, 1'b0, IDLE);
        tick();
        check_state("nodv", 1'b1, 1'b0, 4'd3, 1'b0);
        drive(1'b0, 1'b0, 3'd6);
        tick();
        check_state("ill0", 1'b1, 1'b0, 4'd3, 1'b0);
        tick();
        check_state("ill1", 1'b1, 1'b0, 4'd3, 1'b0);
        // Remaining bits 2..7 of 0x0F are 1,1,0,0,0,0.
        drive(1'b0, 1'b0, SRL);
        tick();
        check_state("p.d2", 1'b1, 1'b1, 4'd4, 1'b0);
        tick();
        check_state("p.d3", 1'b1, 1'b1, 4'd5, 1'b0);
        tick();
        check_state("p.d4", 1'b0, 1'b1, 4'd6, 1'b0);
        tick();
        check_state("p.d5", 1'b0, 1'b1, 4'd7, 1'b0);
        tick();
        check_state("p.d6", 1'b0, 1'b1, 4'd8, 1'b0);
        tick();
        check_state("p.d7", 1'b0, 1'b1, 4'd8, 1'b1);
        drive(1'b0, 1'b0, PAR);
        tick();
        check_state("p.par", 1'b0, 1'b1, 4'd8, 1'b1);

        // Reset while parked in SRL with a completed (stale) shift.
        bus.P_DATA = 8'hA5;
        drive(1'b1, 1'b1, IDLE);
        tick();
        drive(1'b0, 1'b0, START);
        tick();
        drive(1'b0, 1'b0, SRL);
        repeat (8) tick();
        check_state("r.pre", 1'b1, 1'b1, 4'd8, 1'b1);
        tick();
        check_state("r.hold", 1'b1, 1'b1, 4'd8, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_state("r.async", 1'b1, 1'b0, 4'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_state($sformatf("r.hold%0d", c), 1'b1, 1'b0, 4'd0, 1'b0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, IDLE);
        tick();
        check_state("r.rel", 1'b1, 1'b0, 4'd0, 1'b0);
        run_frame("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_datapath.md
Name: uart_tx_datapath

Overview:
Bit-level datapath directly downstream of the UART TX control FSM. It consumes the FSM's serializer_load and sel_line controls, captures the parallel byte and parity configuration, and shifts the data LSB-first. It returns counter and SRL_done to the FSM and drives the registered serial line TX_OUT. One bit is emitted per clk; baud pacing is handled outside this block.

Parameters:
WIDTH, 8, data bits per frame (1..15; counter is 4 bits)
SEL_IDLE, 0, sel_line code for idle (line high)
SEL_START, 1, sel_line code for start bit
SEL_STP, 2, sel_line code for stop bit
SEL_SRL, 3, sel_line code for data bits
SEL_PAR, 4, sel_line code for parity bit

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
P_DATA  input  WIDTH  parallel byte from upstream
DATA_VALID  input  1  P_DATA valid
PAR_EN  input  1  parity enable (pass-through to the FSM; not used internally)
PAR_TYP  input  1  0 = even parity, 1 = odd parity
serializer_load  input  1  load strobe from the FSM
sel_line  input  3  output-mux select from the FSM
counter  output  4  data bits presented so far, including the current one
SRL_done  output  1  high once all WIDTH bits are shifted
TX_OUT  output  1  registered serial line
tx_busy  output  1  frame in progress (start, data or parity phase)

Behaviour:
- Reset (async, rst=1): shreg=0, par_bit=0, counter=0, SRL_done=0, TX_OUT=1, tx_busy=0. Any frame in flight is abandoned. The line goes high immediately and stays high until rst deasserts.
- Load, when serializer_load=1 && DATA_VALID=1:
  - shreg <= P_DATA.
  - par_bit <= ^P_DATA when PAR_TYP=0, ~^P_DATA when PAR_TYP=1.
  - counter <= 0, SRL_done <= 0.
- serializer_load=1 && DATA_VALID=0: all state holds.
- Load has priority over shift when serializer_load=1 coincides with any sel_line value.
- PAR_TYP and P_DATA changes after the load edge do not affect the current frame.
- sel_line==SEL_START: counter <= 1 (pre-arm). No shift.
- sel_line==SEL_SRL && counter<=WIDTH-1:
  - shreg shifts right one place (MSB filled with 0).
  - counter <= counter+1.
  - TX_OUT <= shreg[0] (the pre-shift value).
- sel_line==SEL_SRL && counter==WIDTH:
  - Last data cycle. TX_OUT <= shreg[0], SRL_done <= 1, counter holds at WIDTH.
  - Exactly WIDTH cycles are spent in SEL_SRL per frame.
- Counter saturates at WIDTH and never wraps.
- TX_OUT is registered: TX_OUT <= mux(sel_line) at each edge, so the line lags sel_line by exactly 1 cycle.
  - SEL_IDLE -> 1
  - SEL_START -> 0
  - SEL_SRL -> shreg[0]
  - SEL_PAR -> par_bit
  - SEL_STP -> 1
  - codes 5..7 -> 1 (safe idle)
- tx_busy is registered: tx_busy <= (sel_line is SEL_START, SEL_SRL or SEL_PAR). It lags by 1 cycle, aligned with TX_OUT.
- SRL_done clears only on load or reset. It stays high through the parity and stop phases.
- rst asserted mid-shift: on release, counter=0 and TX_OUT=1. A stale SRL_done is never visible after reset.

Test Plan:
- Reset: hold rst=1 for 3 cycles during an active SEL_SRL -> TX_OUT=1, counter=0, SRL_done=0, tx_busy=0 immediately (async) and after release.
- Even-parity frame: P_DATA=0xA5, PAR_TYP=0, sequence load, START, SRL x8, PAR, STP -> TX_OUT from 1 cycle later = 0,1,0,1,0,0,1,0,1,0,1. Counter reads 1..8 across the SRL cycles; SRL_done=1 after the 8th.
- Odd parity: P_DATA=0x07, PAR_TYP=1 -> parity bit on TX_OUT = 0. With P_DATA=0x03, PAR_TYP=1 -> parity bit = 1.
- Config change mid-frame: load 0xFF with PAR_TYP=0, then set PAR_TYP=1 and P_DATA=0x00 during SRL -> data bits all 1, parity bit = 0.
- Load with DATA_VALID=0: serializer_load=1, DATA_VALID=0, P_DATA=0x3C -> shreg, counter and SRL_done unchanged from the previous frame.
- Illegal select: drive sel_line=6 for 2 cycles mid-frame -> TX_OUT=1, tx_busy=0, shreg and counter unchanged.
